ram_port_arbiter: RTL and testbench

//   Shares one port of an altsyncram RAM between NUM_REQ requesters.
//   - Round-robin arbitration, valid/ready request handshake.
//   - Registered issue of wren/rden/address/data to the RAM.
//   - Each requester's read data is returned after a fixed latency,

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_port_arbiter_if.sv | 34 +++
 rtl/rr_arbiter_core.sv | 36 +++
 rtl/ram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and limits for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned MAX_REQ        = 8;
  localparam int unsigned MAX_RD_LATENCY = 4;
  localparam int unsigned IDX_W          = $clog2(MAX_REQ);

  // Requester index, wide enough for the largest supported requester count.
  typedef logic [IDX_W-1:0] idx_t;

  // One read-return tag: valid flag plus the requester that issued the read.
  typedef struct packed {
    logic vld;
    idx_t idx;
  } tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request, response and RAM-side signals of the RAM port arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned WIDTHAD = 8
);

  logic                       en;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_wr;
  logic [NUM_REQ*WIDTHAD-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [WIDTH-1:0]           rsp_rdata;
  logic                       mem_wren;
  logic                       mem_rden;
  logic [WIDTHAD-1:0]         mem_addr;
  logic [WIDTH-1:0]           mem_data;
  logic [WIDTH-1:0]           mem_q;

  // Arbiter side.
  modport slave (
    input  en, req_valid, req_wr, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_rdata, mem_wren, mem_rden, mem_addr, mem_data
  );

  // Client engines and RAM side.
  modport master (
    output en, req_valid, req_wr, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, mem_wren, mem_rden, mem_addr, mem_data
  );

endinterface

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin grant: highest priority goes to ptr+1, wrapping.
module rr_arbiter_core
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  idx_t               ptr,
  output logic [NUM_REQ-1:0] grant,
  output idx_t               grant_idx
);

  logic found;

  // Two ordered passes replace rotate/encode/un-rotate: indices above ptr first, then the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (idx_t'(i) > ptr)) begin
        grant[i]  = 1'b1;
        grant_idx = idx_t'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (idx_t'(i) <= ptr)) begin
        grant[i]  = 1'b1;
        grant_idx = idx_t'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one altsyncram port between NUM_REQ requesters with round-robin
// arbitration, registered issue and tagged fixed-latency read return.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WIDTHAD    = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input logic               clock,
  input logic               aclr,
  ram_port_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] arb_valid;
  logic [NUM_REQ-1:0] grant;
  idx_t               grant_idx;
  logic               any_grant;
  idx_t               ptr_q;

  logic               sel_wr;
  logic [WIDTHAD-1:0] sel_addr;
  logic [WIDTH-1:0]   sel_data;

  logic               mem_wren_q;
  logic               mem_rden_q;
  logic [WIDTHAD-1:0] mem_addr_q;
  logic [WIDTH-1:0]   mem_data_q;
  idx_t               issue_idx_q;

  tag_t               tag_q [RD_LATENCY];
  tag_t               tag_out;
  logic [WIDTH-1:0]   rdata_q;

  assign arb_valid = bus.en ? bus.req_valid : '0;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_core (
    .valid     (arb_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_grant     = |grant;
  assign bus.req_ready = grant;

  // One-hot AND-OR mux of the granted requester's command fields.
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_wr   = sel_wr | bus.req_wr[i];
        sel_addr = sel_addr | bus.req_addr[i*WIDTHAD +: WIDTHAD];
        sel_data = sel_data | bus.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin pointer remembers the last granted requester.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ptr_q <= idx_t'(NUM_REQ - 1);
    end else if (any_grant) begin
      ptr_q <= grant_idx;
    end
  end

  // Registered issue to the RAM; address and data hold while idle.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      issue_idx_q <= '0;
    end else begin
      mem_wren_q <= any_grant & sel_wr;
      mem_rden_q <= any_grant & ~sel_wr;
      if (any_grant) begin
        mem_addr_q  <= sel_addr;
        mem_data_q  <= sel_data;
        issue_idx_q <= grant_idx;
      end
    end
  end

  assign bus.mem_wren = mem_wren_q;
  assign bus.mem_rden = mem_rden_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;

  // Tag shift register tracks each read through the RAM's latency.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: mem_rden_q, idx: issue_idx_q};
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[RD_LATENCY-1];

  // Decode the returning tag into a one-hot response strobe.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = tag_out.vld && (tag_out.idx == idx_t'(i));
    end
  end

  // Capture returned data so rsp_rdata holds between responses.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rdata_q <= '0;
    end else if (tag_out.vld) begin
      rdata_q <= bus.mem_q;
    end
  end

  assign bus.rsp_rdata = tag_out.vld ? bus.mem_q : rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a 2-cycle RAM model and a
// response scoreboard.
module tb_ram_port_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned WIDTHAD    = 8;
  localparam int unsigned RD_LATENCY = 2;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic aclr;
  int   checks = 0;
  int   fails  = 0;

  exp_t       exp_q [$];
  logic [7:0] exp_mem [256];

  // RAM model storage (read-old-data on collision, 2-cycle read latency).
  logic [7:0] ram [256];
  logic       written [256];
  logic [7:0] ram_s1;
  logic [7:0] ram_q;

  always #5 clock = ~clock;

  ram_port_arbiter_if #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .WIDTHAD (WIDTHAD)
  ) bus ();

  ram_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WIDTH      (WIDTH),
    .WIDTHAD    (WIDTHAD),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .clock (clock),
    .aclr  (aclr),
    .bus   (bus)
  );

  function automatic logic [7:0] init_val(int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  always @(posedge clock) begin
    if (bus.mem_wren) begin
      ram[bus.mem_addr]     <= bus.mem_data;
      written[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_rden) begin
      ram_s1 <= (written[bus.mem_addr] === 1'b1) ? ram[bus.mem_addr] : init_val(int'(bus.mem_addr));
    end else begin
      ram_s1 <= 8'hEE;
    end
    ram_q <= ram_s1;
  end

  assign bus.mem_q = ram_q;

  // Scoreboard: every response strobe must match the oldest expected read.
  always @(negedge clock) begin
    if (aclr === 1'b0 && bus.rsp_valid !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: rsp_valid=%b with no read outstanding", bus.rsp_valid);
      end else begin
        exp_t       e;
        logic [3:0] ev;
        e      = exp_q.pop_front();
        ev     = '0;
        ev[e.idx] = 1'b1;
        if (bus.rsp_valid !== ev || bus.rsp_rdata !== e.data) begin
          fails++;
          $display("FAIL sb_rsp: got valid=%b data=%h, expected valid=%b data=%h",
                   bus.rsp_valid, bus.rsp_rdata, ev, e.data);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(int i, logic wr, logic [7:0] addr, logic [7:0] data);
    bus.req_wr[i]           = wr;
    bus.req_addr[i*8 +: 8]  = addr;
    bus.req_wdata[i*8 +: 8] = data;
  endtask

  task automatic test_reset();
    aclr          = 1'b1;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int a = 0; a < 256; a++) begin
      exp_mem[a] = init_val(a);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 0000", bus.req_ready);
    end
    checks++;
    if ({bus.mem_wren, bus.mem_rden, bus.mem_addr, bus.mem_data} !== 18'h0) begin
      fails++;
      $display("FAIL reset_mem: got wren=%b rden=%b addr=%h data=%h, expected all 0",
               bus.mem_wren, bus.mem_rden, bus.mem_addr, bus.mem_data);
    end
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_rdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_rsp: got valid=%b data=%h, expected 0/00", bus.rsp_valid, bus.rsp_rdata);
    end
    aclr          = 1'b0;
    bus.en        = 1'b1;
    bus.req_valid = 4'b0011;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL reset_first_grant: got %b, expected 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    cycle();
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b1, 8'(10 + i), 8'(8'h20 + i));
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] ev;
      int         g;
      g  = k % 4;
      ev = 4'(1 << g);
      #1;
      checks++;
      if (bus.req_ready !== ev) begin
        fails++;
        $display("FAIL rot_grant[%0d]: got %b, expected %b", k, bus.req_ready, ev);
      end
      exp_mem[10 + g] = 8'(8'h20 + g);
      cycle();
      checks++;
      if (bus.mem_wren !== 1'b1 || bus.mem_rden !== 1'b0 ||
          bus.mem_addr !== 8'(10 + g) || bus.mem_data !== 8'(8'h20 + g)) begin
        fails++;
        $display("FAIL rot_issue[%0d]: got wren=%b rden=%b addr=%0d data=%h, expected 1/0/%0d/%h",
                 k, bus.mem_wren, bus.mem_rden, bus.mem_addr, bus.mem_data, 10 + g, 8'h20 + g);
      end
    end
    bus.req_valid = '0;
    cycle();
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.mem_rden !== 1'b0 || bus.mem_addr !== 8'd10) begin
      fails++;
      $display("FAIL idle_issue: got wren=%b rden=%b addr=%0d, expected 0/0/10",
               bus.mem_wren, bus.mem_rden, bus.mem_addr);
    end
  endtask

  task automatic test_write_read();
    bus.req_wr = '0;
    set_req(2, 1'b1, 8'd5, 8'hA5);
    set_req(1, 1'b0, 8'd5, 8'h00);
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL wr_grant: got %b, expected 0100", bus.req_ready);
    end
    exp_mem[5] = 8'hA5;
    cycle();
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL rd_grant: got %b, expected 0010", bus.req_ready);
    end
    exp_q.push_back('{idx: 1, data: exp_mem[5]});
    cycle();
    bus.req_valid = '0;
    checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_wren !== 1'b0 || bus.mem_addr !== 8'd5) begin
      fails++;
      $display("FAIL rd_issue: got rden=%b wren=%b addr=%0d, expected 1/0/5",
               bus.mem_rden, bus.mem_wren, bus.mem_addr);
    end
    cycle();
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      fails++;
      $display("FAIL rd_early: got rsp_valid=%b one cycle after rden, expected 0000", bus.rsp_valid);
    end
    cycle();
    checks++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL rd_latency: got valid=%b data=%h, expected 0010/a5", bus.rsp_valid, bus.rsp_rdata);
    end
    cycle();
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL rd_hold: got valid=%b data=%h, expected 0000/a5", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bus.req_wr = '0;
    set_req(0, 1'b0, 8'd1, 8'h00);
    set_req(3, 1'b0, 8'd2, 8'h00);
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL b2b_grant0: got %b, expected 0001", bus.req_ready);
    end
    exp_q.push_back('{idx: 0, data: exp_mem[1]});
    cycle();
    bus.req_valid = 4'b1000;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_grant3: got %b, expected 1000", bus.req_ready);
    end
    exp_q.push_back('{idx: 3, data: exp_mem[2]});
    cycle();
    bus.req_valid = '0;
    cycle();
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== exp_mem[1]) begin
      fails++;
      $display("FAIL b2b_rsp0: got valid=%b data=%h, expected 0001/%h",
               bus.rsp_valid, bus.rsp_rdata, exp_mem[1]);
    end
    cycle();
    checks++;
    if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== exp_mem[2]) begin
      fails++;
      $display("FAIL b2b_rsp3: got valid=%b data=%h, expected 1000/%h",
               bus.rsp_valid, bus.rsp_rdata, exp_mem[2]);
    end
    cycle();
  endtask

  task automatic test_enable();
    bus.req_wr = '0;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b0, 8'(20 + i), 8'h00);
    end
    bus.req_valid = 4'b0010;
    #1;
    exp_q.push_back('{idx: 1, data: exp_mem[21]});
    cycle();
    bus.en        = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL en_ready[%0d]: got %b, expected 0000", k, bus.req_ready);
      end
      cycle();
      checks++;
      if (bus.mem_wren !== 1'b0 || bus.mem_rden !== 1'b0) begin
        fails++;
        $display("FAIL en_issue[%0d]: got wren=%b rden=%b, expected 0/0", k, bus.mem_wren, bus.mem_rden);
      end
    end
    bus.en = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL en_resume: got %b, expected 0100", bus.req_ready);
    end
    exp_q.push_back('{idx: 2, data: exp_mem[22]});
    cycle();
    bus.req_valid = '0;
    repeat (4) cycle();
  endtask

  task automatic test_aclr_flush();
    int rsp_seen;
    rsp_seen   = 0;
    bus.req_wr = '0;
    set_req(2, 1'b0, 8'd7, 8'h00);
    bus.req_valid = 4'b0100;
    cycle();
    bus.req_valid = '0;
    cycle();
    aclr = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (bus.mem_rden !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
      fails++;
      $display("FAIL aclr_async: got rden=%b rsp_valid=%b, expected 0/0000", bus.mem_rden, bus.rsp_valid);
    end
    cycle();
    aclr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.rsp_valid !== 4'b0000) rsp_seen++;
      cycle();
    end
    checks++;
    if (rsp_seen != 0) begin
      fails++;
      $display("FAIL aclr_discard: got %0d responses after reset, expected 0", rsp_seen);
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL aclr_ptr: got %b, expected 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_write_read();
    test_back_to_back();
    test_enable();
    test_aclr_flush();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d reads still outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
